movement_scheduler: RTL and testbench



---
 rtl/movement_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_movement_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/movement_scheduler.sv
// movement_scheduler: frame-rate clear/move/draw sequencer driving the movement datapath
// (PorB=0 player, PorB=1 bird). Optional macro DIAGONAL_MOVE_EN allows two moves per object per frame.
module movement_scheduler #(
    parameter int unsigned FRAME_DIV      = 833333,
    parameter int unsigned ENABLE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p_dir,
    input  logic [3:0] b_dir,
    input  logic       dp_enable,
    output logic [3:0] control,
    output logic       PorB,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        ST_PREHOLD = 4'b0100,
        ST_HOLD    = 4'b0000,
        ST_CLEAR   = 4'b0001,
        ST_LEFT    = 4'b0011,
        ST_RIGHT   = 4'b0010,
        ST_DOWN    = 4'b0110,
        ST_UP      = 4'b0111,
        ST_DRAW    = 4'b0101
    } state_t;

    localparam logic [19:0] FRAME_LAST = 20'(FRAME_DIV - 1);
    localparam logic [4:0]  WAIT_LAST  = 5'(ENABLE_TIMEOUT - 1);

    state_t      state_r;
    state_t      move1_r;
    state_t      move2_r;
    state_t      p_move1_s;
    state_t      p_move2_s;
    state_t      b_move1_s;
    state_t      b_move2_s;
    logic [19:0] frame_cnt_r;
    logic [4:0]  wait_r;
    logic        pending_r;
    logic        init_r;
    logic        tick_s;
    logic [3:0]  control_r;
    logic        porb_r;
    logic        busy_r;
    logic        frame_done_r;
    logic        timeout_err_r;

    // ST_HOLD doubles as "no move" in the direction decoders.
    function automatic state_t h_move(input logic [3:0] dir);
        state_t m;
        case (dir[3:2])
            2'b10:   m = ST_LEFT;
            2'b01:   m = ST_RIGHT;
            default: m = ST_HOLD;
        endcase
        return m;
    endfunction

    function automatic state_t v_move(input logic [3:0] dir);
        state_t m;
        case (dir[1:0])
            2'b10:   m = ST_UP;
            2'b01:   m = ST_DOWN;
            default: m = ST_HOLD;
        endcase
        return m;
    endfunction

    function automatic state_t first_move(input logic [3:0] dir, input logic suppress);
        state_t m;
        if (suppress) begin
            m = ST_HOLD;
        end else if (h_move(dir) != ST_HOLD) begin
            m = h_move(dir);
        end else begin
            m = v_move(dir);
        end
        return m;
    endfunction

    assign tick_s = (frame_cnt_r == FRAME_LAST);

    // Move plan for the object whose CLEAR is entered next.
    always_comb begin
        p_move1_s = first_move(p_dir, init_r);
        b_move1_s = first_move(b_dir, init_r);
`ifdef DIAGONAL_MOVE_EN
        p_move2_s = (p_move1_s inside {ST_LEFT, ST_RIGHT}) ? v_move(p_dir) : ST_HOLD;
        b_move2_s = (b_move1_s inside {ST_LEFT, ST_RIGHT}) ? v_move(b_dir) : ST_HOLD;
`else
        p_move2_s = ST_HOLD;
        b_move2_s = ST_HOLD;
`endif
    end

    // Free-running frame divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 20'd0;
        end else if (tick_s) begin
            frame_cnt_r <= 20'd0;
        end else begin
            frame_cnt_r <= frame_cnt_r + 20'd1;
        end
    end

    // Frame sequencer with registered control/PorB/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_PREHOLD;
            move1_r       <= ST_HOLD;
            move2_r       <= ST_HOLD;
            wait_r        <= 5'd0;
            pending_r     <= 1'b0;
            init_r        <= 1'b1;
            control_r     <= 4'b0000;
            porb_r        <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // Single-entry tick memory: a tick while already pending is lost.
            if (tick_s && (state_r != ST_HOLD)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_PREHOLD: begin
                    state_r   <= ST_CLEAR;
                    control_r <= ST_CLEAR;
                    busy_r    <= 1'b1;
                    porb_r    <= 1'b0;
                    wait_r    <= 5'd0;
                    move1_r   <= p_move1_s;
                    move2_r   <= p_move2_s;
                end
                ST_HOLD: begin
                    if (tick_s || pending_r) begin
                        pending_r <= 1'b0;
                        state_r   <= ST_CLEAR;
                        control_r <= ST_CLEAR;
                        busy_r    <= 1'b1;
                        porb_r    <= 1'b0;
                        wait_r    <= 5'd0;
                        move1_r   <= p_move1_s;
                        move2_r   <= p_move2_s;
                    end else begin
                        state_r   <= ST_HOLD;
                        control_r <= ST_HOLD;
                    end
                end
                ST_CLEAR, ST_DRAW: begin
                    if (dp_enable || (wait_r == WAIT_LAST)) begin
                        if (!dp_enable) begin
                            timeout_err_r <= 1'b1;
                        end
                        wait_r <= 5'd0;
                        if (state_r == ST_CLEAR) begin
                            if (move1_r != ST_HOLD) begin
                                state_r   <= move1_r;
                                control_r <= move1_r;
                            end else begin
                                state_r   <= ST_DRAW;
                                control_r <= ST_DRAW;
                            end
                        end else if (!porb_r) begin
                            state_r   <= ST_CLEAR;
                            control_r <= ST_CLEAR;
                            porb_r    <= 1'b1;
                            move1_r   <= b_move1_s;
                            move2_r   <= b_move2_s;
                        end else begin
                            state_r      <= ST_HOLD;
                            control_r    <= ST_HOLD;
                            porb_r       <= 1'b0;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                            init_r       <= 1'b0;
                        end
                    end else begin
                        wait_r <= wait_r + 5'd1;
                    end
                end
                ST_LEFT, ST_RIGHT, ST_UP, ST_DOWN: begin
                    wait_r <= 5'd0;
                    if (move2_r != ST_HOLD) begin
                        state_r   <= move2_r;
                        control_r <= move2_r;
                        move2_r   <= ST_HOLD;
                    end else begin
                        state_r   <= ST_DRAW;
                        control_r <= ST_DRAW;
                    end
                end
                default: begin
                    state_r   <= ST_HOLD;
                    control_r <= ST_HOLD;
                    porb_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    wait_r    <= 5'd0;
                end
            endcase
        end
    end

    assign control     = control_r;
    assign PorB        = porb_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_movement_scheduler.sv
// Self-checking bench for movement_scheduler: scoreboard of expected control/PorB segments.
`timescale 1ns/1ps
module tb_movement_scheduler;

    typedef struct packed {
        logic       porb;
        logic [3:0] code;
        logic [7:0] len;
    } seg_t;

    localparam logic [3:0] C_CLEAR = 4'b0001;
    localparam logic [3:0] C_DRAW  = 4'b0101;
    localparam logic [3:0] C_LEFT  = 4'b0011;
    localparam logic [3:0] C_RIGHT = 4'b0010;
    localparam logic [3:0] C_DOWN  = 4'b0110;
    localparam logic [3:0] C_UP    = 4'b0111;
    localparam logic [3:0] C_NONE  = 4'b0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p_dir, b_dir;
    logic       dp_enable;
    logic [3:0] control;
    logic       PorB, busy, frame_done, timeout_err;

    logic       rst2, en2;
    logic [3:0] p_dir2, b_dir2, control2;
    logic       porb2, busy2, frame_done2, timeout_err2;

    int   n_cmp = 0;
    int   n_bad = 0;
    seg_t exp_q[$];
    int   dly_q[$];

    always #5 clk = ~clk;

    movement_scheduler #(.FRAME_DIV(64), .ENABLE_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .p_dir(p_dir), .b_dir(b_dir), .dp_enable(dp_enable),
        .control(control), .PorB(PorB), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    // Short frame period so enable delays can span several ticks.
    movement_scheduler #(.FRAME_DIV(20), .ENABLE_TIMEOUT(15)) dut_stress (
        .clk(clk), .reset(rst2), .p_dir(p_dir2), .b_dir(b_dir2), .dp_enable(en2),
        .control(control2), .PorB(porb2), .busy(busy2), .frame_done(frame_done2),
        .timeout_err(timeout_err2)
    );

    // Datapath model: pulses dp_enable on the d-th cycle of each CLEAR/DRAW (d=0: never).
    initial begin
        logic [4:0] r_prev;
        logic [4:0] r_cur;
        int         left;
        r_prev = 5'd0;
        left   = -1;
        dp_enable = 1'b0;
        forever begin
            @(negedge clk);
            dp_enable = 1'b0;
            if (reset) begin
                r_prev = 5'd0;
                left   = -1;
            end else begin
                r_cur = {PorB, control};
                if ((r_cur != r_prev) && (control == C_CLEAR || control == C_DRAW)) begin
                    left = (dly_q.size() != 0) ? dly_q.pop_front() : 4;
                end else if (!(control == C_CLEAR || control == C_DRAW)) begin
                    left = -1;
                end
                if (left > 0) begin
                    left = left - 1;
                    if (left == 0) dp_enable = 1'b1;
                end
                r_prev = r_cur;
            end
        end
    end

    // Monitor: each closed non-HOLD segment is compared against the scoreboard head.
    initial begin
        logic [4:0] prev_v;
        logic [4:0] cur_v;
        int         run;
        seg_t       e;
        prev_v = 5'd0;
        run    = 0;
        forever begin
            @(negedge clk);
            cur_v = {PorB, control};
            if (reset) begin
                prev_v = 5'd0;
                run    = 0;
            end else if (cur_v == prev_v) begin
                run++;
            end else begin
                if (prev_v[3:0] != 4'b0000) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL seq_unexpected: got PorB=%0d control=%b len=%0d, required no segment",
                                 prev_v[4], prev_v[3:0], run);
                    end else begin
                        e = exp_q.pop_front();
                        if ({prev_v, 8'(run)} !== {e.porb, e.code, e.len}) begin
                            n_bad++;
                            $display("FAIL seq_segment: got PorB=%0d control=%b len=%0d, required PorB=%0d control=%b len=%0d",
                                     prev_v[4], prev_v[3:0], run, e.porb, e.code, e.len);
                        end
                    end
                end
                prev_v = cur_v;
                run    = 1;
            end
        end
    end

    task automatic push_seg(input logic porb, input logic [3:0] code, input int len);
        seg_t s;
        s.porb = porb;
        s.code = code;
        s.len  = 8'(len);
        exp_q.push_back(s);
    endtask

    // Expected frame; C_NONE move slots are skipped. Plot lengths follow the responder delay.
    task automatic push_frame(input logic [3:0] pm1, input logic [3:0] pm2,
                              input logic [3:0] bm1, input logic [3:0] bm2, input int pclr_len);
        push_seg(1'b0, C_CLEAR, pclr_len);
        if (pm1 != C_NONE) push_seg(1'b0, pm1, 1);
        if (pm2 != C_NONE) push_seg(1'b0, pm2, 1);
        push_seg(1'b0, C_DRAW, 4);
        push_seg(1'b1, C_CLEAR, 4);
        if (bm1 != C_NONE) push_seg(1'b1, bm1, 1);
        if (bm2 != C_NONE) push_seg(1'b1, bm2, 1);
        push_seg(1'b1, C_DRAW, 4);
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (frame_done) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_pending();
        int         starts[$];
        int         dones[$];
        logic [3:0] pc;
        bit         fast;
        rst2 = 1'b1; en2 = 1'b0; p_dir2 = 4'b0000; b_dir2 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        pc   = 4'b0000;
        fast = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (control2 == C_CLEAR && !porb2 && pc != C_CLEAR) starts.push_back(k);
            if (frame_done2) begin
                dones.push_back(k);
                fast = 1'b1;
            end
            if (k == 40 || k == 63) begin
                n_cmp++;
                if (busy2 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pending_busy: cycle %0d busy=%b required 1", k, busy2);
                end
            end
            en2 = fast && (control2 == C_CLEAR || control2 == C_DRAW);
            pc  = control2;
        end
        n_cmp++;
        if (starts.size() != 3) begin
            n_bad++;
            $display("FAIL pending_starts_count: got %0d frame starts, required 3", starts.size());
        end else if (starts[0] != 1 || starts[1] != 62 || starts[2] != 80) begin
            n_bad++;
            $display("FAIL pending_starts: got %0d,%0d,%0d required 1,62,80", starts[0], starts[1], starts[2]);
        end
        n_cmp++;
        if (dones.size() != 3) begin
            n_bad++;
            $display("FAIL pending_dones_count: got %0d frame_done pulses, required 3", dones.size());
        end else if (dones[0] != 61 || dones[1] != 66 || dones[2] != 84) begin
            n_bad++;
            $display("FAIL pending_dones: got %0d,%0d,%0d required 61,66,84", dones[0], dones[1], dones[2]);
        end
        n_cmp++;
        if (timeout_err2 !== 1'b1) begin
            n_bad++;
            $display("FAIL pending_timeout_err: got %b required 1", timeout_err2);
        end
        rst2 = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1; p_dir = 4'b1000; b_dir = 4'b0001;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({control, PorB, busy, frame_done, timeout_err} !== 8'b0000_0000) begin
            n_bad++;
            $display("FAIL reset_values: control=%b PorB=%b busy=%b frame_done=%b timeout_err=%b required all 0",
                     control, PorB, busy, frame_done, timeout_err);
        end
        push_frame(C_NONE, C_NONE, C_NONE, C_NONE, 4);
        reset = 1'b0;
        wait_frame(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL init_frame_done: frame_done=0 required pulse"); end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL init_seq_left: %0d segments outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if ({frame_done, busy, timeout_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL init_after: frame_done=%b busy=%b timeout_err=%b required 0", frame_done, busy, timeout_err);
        end
    endtask

    task automatic test_moves();
        bit ok;
        p_dir = 4'b1000; b_dir = 4'b0001;
        push_frame(C_LEFT, C_NONE, C_DOWN, C_NONE, 4);
        wait_frame(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL moves_frame: done=%0d outstanding=%0d required done=1 outstanding=0", ok, exp_q.size());
        end
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL moves_timeout_err: got %b required 0", timeout_err);
        end
    endtask

    task automatic test_conflict();
        bit ok;
        p_dir = 4'b1100; b_dir = 4'b0000;
        push_frame(C_NONE, C_NONE, C_NONE, C_NONE, 4);
        wait_frame(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL conflict_lr: done=%0d outstanding=%0d required done=1 outstanding=0", ok, exp_q.size());
        end
        p_dir = 4'b1010; b_dir = 4'b0011;
`ifdef DIAGONAL_MOVE_EN
        push_frame(C_LEFT, C_UP, C_NONE, C_NONE, 4);
`else
        push_frame(C_LEFT, C_NONE, C_NONE, C_NONE, 4);
`endif
        wait_frame(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL conflict_diag: done=%0d outstanding=%0d required done=1 outstanding=0", ok, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        p_dir = 4'b0000; b_dir = 4'b0000;
        dly_q.push_back(0);
        push_frame(C_NONE, C_NONE, C_NONE, C_NONE, 15);
        wait_frame(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_frame: done=%0d outstanding=%0d required done=1 outstanding=0", ok, exp_q.size());
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err_set: got %b required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        p_dir = 4'b0100; b_dir = 4'b0100;
        push_seg(1'b0, C_CLEAR, 4);
        push_seg(1'b0, C_RIGHT, 1);
        push_seg(1'b0, C_DRAW, 4);
        push_seg(1'b1, C_CLEAR, 4);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (PorB && control == C_RIGHT) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mid_reach_move: bird move not reached, required RIGHT"); end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err_sticky: got %b required 1", timeout_err);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({control, PorB, busy} !== 6'b000000) begin
            n_bad++;
            $display("FAIL mid_reset_async: control=%b PorB=%b busy=%b required 0000 0 0", control, PorB, busy);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_seq_left: %0d segments outstanding, required 0", exp_q.size());
        end
        dly_q.delete();
        repeat (2) @(negedge clk);
        push_frame(C_NONE, C_NONE, C_NONE, C_NONE, 4);
        reset = 1'b0;
        wait_frame(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_init_rerun: done=%0d outstanding=%0d required done=1 outstanding=0", ok, exp_q.size());
        end
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_timeout_cleared: got %b required 0", timeout_err);
        end
    endtask

    initial begin
        reset = 1'b1; rst2 = 1'b1; en2 = 1'b0;
        p_dir = 4'b0000; b_dir = 4'b0000; p_dir2 = 4'b0000; b_dir2 = 4'b0000;
        test_pending();
        test_reset();
        test_moves();
        test_conflict();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
